// File: rtl/median_window_scanner.sv
// Raster-scans every window centre of an image and streams each WIN x WIN neighbourhood address (border-clamped) to memory.
// Define MEDIAN_SKIP_BORDER_EN to scan only centres whose full window lies inside the image.
module median_window_scanner #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 8,
  parameter int WIN   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic [AW-1:0] x_addr,
  output logic [AW-1:0] y_addr,
  output logic          win_last,
  output logic [AW-1:0] center_x,
  output logic [AW-1:0] center_y,
  input  logic          med_done
);

  localparam int R  = (WIN - 1) / 2;
  localparam int SW = AW + 2;

`ifdef MEDIAN_SKIP_BORDER_EN
  localparam int X_FIRST_I = R;
  localparam int Y_FIRST_I = R;
  localparam int X_LAST_I  = IMG_W - 1 - R;
  localparam int Y_LAST_I  = IMG_H - 1 - R;
`else
  localparam int X_FIRST_I = 0;
  localparam int Y_FIRST_I = 0;
  localparam int X_LAST_I  = IMG_W - 1;
  localparam int Y_LAST_I  = IMG_H - 1;
`endif

  localparam logic [AW-1:0] X_FIRST = AW'(X_FIRST_I);
  localparam logic [AW-1:0] Y_FIRST = AW'(Y_FIRST_I);
  localparam logic [AW-1:0] X_LAST  = AW'(X_LAST_I);
  localparam logic [AW-1:0] Y_LAST  = AW'(Y_LAST_I);
  localparam logic [AW-1:0] C_ONE   = AW'(1);

  localparam logic signed [SW-1:0] R_POS = SW'(R);
  localparam logic signed [SW-1:0] R_NEG = -SW'(R);
  localparam logic signed [SW-1:0] O_ONE = SW'(1);
  localparam logic signed [SW-1:0] X_HI  = SW'(IMG_W - 1);
  localparam logic signed [SW-1:0] Y_HI  = SW'(IMG_H - 1);

  typedef enum logic [2:0] {
    IDLE,
    EMIT,
    WAIT_MED,
    ADV,
    FIN
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          cx_q, cx_d;
  logic [AW-1:0]          cy_q, cy_d;
  logic signed [SW-1:0]   dx_q, dx_d;
  logic signed [SW-1:0]   dy_q, dy_d;
  logic                   last_offset;
  logic                   last_centre;

  // Two guard bits keep centre+offset from wrapping before it is clamped.
  function automatic logic [AW-1:0] clamp_axis(input logic [AW-1:0] c,
                                               input logic signed [SW-1:0] off,
                                               input logic signed [SW-1:0] hi);
    logic signed [SW-1:0] sum;
    sum = $signed({2'b00, c}) + off;
    if (sum[SW-1])
      return '0;
    else if (sum > hi)
      return hi[AW-1:0];
    else
      return sum[AW-1:0];
  endfunction

  assign last_offset = (dx_q == R_POS) && (dy_q == R_POS);
  assign last_centre = (cx_q == X_LAST) && (cy_q == Y_LAST);

  assign addr_valid = (state_q == EMIT);
  assign win_last   = addr_valid && last_offset;
  assign busy       = (state_q == EMIT) || (state_q == WAIT_MED) || (state_q == ADV);
  assign done       = (state_q == FIN);
  assign x_addr     = clamp_axis(cx_q, dx_q, X_HI);
  assign y_addr     = clamp_axis(cy_q, dy_q, Y_HI);
  assign center_x   = cx_q;
  assign center_y   = cy_q;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          cx_d    = X_FIRST;
          cy_d    = Y_FIRST;
          dx_d    = R_NEG;
          dy_d    = R_NEG;
        end
      end
      EMIT: begin
        // Offsets only move on an accepted transfer, so a stalled address holds.
        if (addr_ready) begin
          if (last_offset) begin
            state_d = WAIT_MED;
          end else if (dx_q == R_POS) begin
            dx_d = R_NEG;
            dy_d = dy_q + O_ONE;
          end else begin
            dx_d = dx_q + O_ONE;
          end
        end
      end
      WAIT_MED: begin
        if (med_done)
          state_d = ADV;
      end
      ADV: begin
        if (last_centre) begin
          state_d = FIN;
        end else begin
          state_d = EMIT;
          dx_d    = R_NEG;
          dy_d    = R_NEG;
          if (cx_q == X_LAST) begin
            cx_d = X_FIRST;
            cy_d = cy_q + C_ONE;
          end else begin
            cx_d = cx_q + C_ONE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

endmodule

// File: tb/tb_median_window_scanner.sv
// Self-checking bench for median_window_scanner on a 4x3 image with a 3x3 window.
// Expected addresses come from a plain clamp-of-centre-plus-offset model of the raster scan.
module tb_median_window_scanner;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int AW    = 8;
  localparam int WIN   = 3;
  localparam int R     = (WIN - 1) / 2;
  localparam int NW    = WIN * WIN;

`ifdef MEDIAN_SKIP_BORDER_EN
  localparam int XF = R;
  localparam int YF = R;
  localparam int XL = IMG_W - 1 - R;
  localparam int YL = IMG_H - 1 - R;
`else
  localparam int XF = 0;
  localparam int YF = 0;
  localparam int XL = IMG_W - 1;
  localparam int YL = IMG_H - 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] x_addr;
  logic [AW-1:0] y_addr;
  logic          win_last;
  logic [AW-1:0] center_x;
  logic [AW-1:0] center_y;
  logic          med_done;

  int checks = 0;
  int errors = 0;
  int total_xfers = 0;

  median_window_scanner #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .AW   (AW),
    .WIN  (WIN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .x_addr    (x_addr),
    .y_addr    (y_addr),
    .win_last  (win_last),
    .center_x  (center_x),
    .center_y  (center_y),
    .med_done  (med_done)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_int(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // k-th address of a window: dx is the inner loop, dy the outer.
  function automatic int model_x(input int cx, input int k);
    return clamp_int(cx + (k % WIN) - R, IMG_W - 1);
  endfunction

  function automatic int model_y(input int cy, input int k);
    return clamp_int(cy + (k / WIN) - R, IMG_H - 1);
  endfunction

  task automatic emit_window(input int cx, input int cy, input int ready_pct,
                             input int stall_k, input bit noise);
    int k = 0;
    int guard = 0;
    int stall = 0;
    while (k < NW && guard < 400) begin
      check_output("emit_valid", addr_valid, 1);
      check_output("emit_x", x_addr, model_x(cx, k));
      check_output("emit_y", y_addr, model_y(cy, k));
      check_output("emit_last", win_last, (k == NW - 1) ? 1 : 0);
      check_output("emit_cx", center_x, cx);
      check_output("emit_cy", center_y, cy);
      if (k == stall_k && stall < 3) begin
        addr_ready = 1'b0;
        stall++;
      end else begin
        addr_ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (noise) begin
        med_done = ($urandom_range(0, 3) == 0);
        start    = ($urandom_range(0, 3) == 0);
      end
      if (addr_ready) begin
        k++;
        total_xfers++;
      end
      cycle();
      guard++;
    end
    addr_ready = 1'b0;
    med_done   = 1'b0;
    start      = 1'b0;
    check_output("window_complete", k, NW);
  endtask

  task automatic scan_image(input int ready_pct, input int stall_k,
                            input int fixed_delay, input bit noise);
    int nwin = 0;
    int delay;
    bit last;
    total_xfers = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_output("start_busy", busy, 1);
    check_output("start_valid", addr_valid, 1);
    for (int cy = YF; cy <= YL; cy++) begin
      for (int cx = XF; cx <= XL; cx++) begin
        emit_window(cx, cy, ready_pct, stall_k, noise);
        nwin++;
        check_output("wait_valid", addr_valid, 0);
        check_output("wait_busy", busy, 1);
        delay = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 5));
        repeat (delay - 1) begin
          cycle();
          check_output("wait_hold", addr_valid, 0);
          check_output("wait_cx", center_x, cx);
        end
        med_done = 1'b1;
        cycle();
        med_done = 1'b0;
        check_output("adv_valid", addr_valid, 0);
        check_output("adv_done", done, 0);
        cycle();
        last = (cx == XL) && (cy == YL);
        if (!last) begin
          check_output("next_valid", addr_valid, 1);
          check_output("next_busy", busy, 1);
        end else begin
          check_output("fin_done", done, 1);
          check_output("fin_busy", busy, 0);
          check_output("fin_valid", addr_valid, 0);
        end
      end
    end
    cycle();
    check_output("idle_done", done, 0);
    check_output("idle_busy", busy, 0);
    check_output("scan_xfers", total_xfers, (XL - XF + 1) * (YL - YF + 1) * NW);
    check_output("scan_windows", nwin, (XL - XF + 1) * (YL - YF + 1));
    repeat (3) begin
      cycle();
      check_output("idle_quiet", done | addr_valid | busy, 0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    addr_ready = 1'b0;
    med_done   = 1'b0;
    repeat (2) cycle();
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_valid", addr_valid, 0);
    check_output("rst_last", win_last, 0);
    check_output("rst_x", x_addr, 0);
    check_output("rst_y", y_addr, 0);
    check_output("rst_cx", center_x, 0);
    check_output("rst_cy", center_y, 0);
    reset = 1'b0;
    med_done = 1'b1;
    cycle();
    med_done = 1'b0;
    check_output("idle_ignores_med", addr_valid | busy, 0);

    // Abort a window at its 4th transfer with a reset that also sees start high.
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_output("t1_busy", busy, 1);
    check_output("t1_cx", center_x, XF);
    check_output("t1_cy", center_y, YF);
    addr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_output("t1_x", x_addr, model_x(XF, i));
      check_output("t1_y", y_addr, model_y(YF, i));
      if (i == 3) begin
        reset = 1'b1;
        start = 1'b1;
      end
      cycle();
    end
    reset      = 1'b0;
    start      = 1'b0;
    addr_ready = 1'b0;
    check_output("t1_rst_valid", addr_valid, 0);
    check_output("t1_rst_busy", busy, 0);
    check_output("t1_rst_cx", center_x, 0);
    check_output("t1_rst_x", x_addr, 0);
    cycle();
    check_output("t1_idle_valid", addr_valid, 0);

    $display("[TB] full scan, ready always high, stall at 5th address, med_done delay 3");
    scan_image(100, 4, 3, 1'b0);

    $display("[TB] full scan, random backpressure and med_done/start noise");
    scan_image(60, -1, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
